lifo_stack: RTL and testbench
=============================

Name: lifo_stack

Overview:
- Complete LIFO stack: push/pop control, storage array, registered read data and status flags.
- Drives the stack-pointer up/down counting (direction + enable) internally and consumes the pointer value to address storage.
- Sits between a producer (push side) and a consumer (pop side) in the LIFO subsystem.

Parameters:
- DATA_W, 8, width of each stored word.
- DEPTH, 32, number of entries; power of two.
- PTR_W, 5, pointer width; equals log2(DEPTH).

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  synchronous reset, active-low.
- push  input  1  write din onto the top of the stack this cycle.
- pop  input  1  read the top entry this cycle.
- din  input  DATA_W  data to push.
- dout  output  DATA_W  popped data, registered.
- dout_valid  output  1  one-cycle pulse; dout holds a new popped word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  PTR_W+1  number of stored entries, 0..DEPTH.
- overflow  output  1  sticky; push was attempted while full.
- underflow  output  1  sticky; pop was attempted while empty.

Behaviour:
- Reset is sampled only at a CLK rising edge while Reset == 0. On reset: count = 0, empty = 1, full = 0, dout = 0, dout_valid = 0, overflow = 0, underflow = 0. Storage contents are not reset.
- A reset asserted mid-operation discards all stored data. A push or pop in the same cycle as reset is ignored.
- Internal pointer sp points to the next free slot; top of stack is sp-1. count and sp update together.
- Push only, not full: mem[sp] <= din; count += 1.
- Push only, full: write suppressed; count unchanged; overflow <= 1.
- Pop only, not empty: dout <= mem[sp-1]; dout_valid <= 1 on the next cycle; count -= 1. Latency is 1 cycle.
- Pop only, empty: dout unchanged; dout_valid <= 0; underflow <= 1.
- Push and pop together, not empty: dout <= mem[sp-1] (old top); mem[sp-1] <= din; count unchanged; dout_valid <= 1. This is legal when full; no overflow.
- Push and pop together, empty: bypass. dout <= din; dout_valid <= 1; count stays 0; no flags set.
- Neither push nor pop: dout holds its value; dout_valid <= 0.
- full and empty are combinational from count and valid in the same cycle as count.
- Pointer arithmetic never wraps. At count == DEPTH the top pointer stays at DEPTH-1 and its carry is used to drive full. Counts DEPTH+1 and -1 are unreachable.
- overflow and underflow clear only on reset.

Optional Feature:
- Macro: LIFO_ALMOST_FLAGS_EN.
- Defined: adds outputs almost_full (count >= DEPTH-AF_MARGIN) and almost_empty (count <= AE_MARGIN). Both are combinational. Adds parameters AF_MARGIN (default 2) and AE_MARGIN (default 2).
- Undefined: neither port nor the parameters exist; the rest of the behaviour is identical.

Decomposition:
- Package lifo_pkg holds:
  - default DATA_W, DEPTH, PTR_W constants;
  - typedef ptr_t (PTR_W bits) and typedef cnt_t (PTR_W+1 bits);
  - an enum op_t {OP_IDLE, OP_PUSH, OP_POP, OP_SWAP} decoded from {push, pop} and empty/full.
- One sub-module: lifo_ptr.
  - Up/down pointer/count register with enable, direction and terminal-carry output.
  - Synchronous active-low reset on CLK/Reset.
  - The top level instantiates it once and keeps storage and the output registers itself.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 cycles -> dout = 0x33, 0x22, 0x11, each with dout_valid one cycle after its pop; final count = 0 and empty = 1.
- Push 32 words 0x00..0x1F, then push 0xAA -> full = 1 after the 32nd push; 33rd push sets overflow = 1, count stays 32; next pop returns 0x1F.
- From reset, pop -> underflow = 1, dout_valid = 0, count = 0; subsequent push 0x5A then pop returns 0x5A and underflow stays 1.
- With count = 2 (top 0x44), assert push = 1 and pop = 1 with din 0x99 -> dout = 0x44, count = 2; next pop returns 0x99. Repeat with count = 0 and din 0x77 -> dout = 0x77, count = 0.
- Push 5 words, assert Reset = 0 for one cycle while pop = 1 -> no dout_valid; count = 0, empty = 1, flags cleared; next pop sets underflow.
- With LIFO_ALMOST_FLAGS_EN defined, fill to 30 -> almost_full = 1 at count 30; drain to 2 -> almost_empty = 1 at count 2.

Source files
------------

// File: rtl/lifo_pkg.sv
// rtl/lifo_pkg.sv - shared constants, types and operation decode for the LIFO stack
package lifo_pkg;

   localparam int LIFO_DATA_W = 8;
   localparam int LIFO_DEPTH  = 32;
   localparam int LIFO_PTR_W  = 5;

   typedef logic [LIFO_PTR_W-1:0] ptr_t;
   typedef logic [LIFO_PTR_W:0]   cnt_t;

   typedef enum logic [1:0] {
      OP_IDLE = 2'd0,
      OP_PUSH = 2'd1,
      OP_POP  = 2'd2,
      OP_SWAP = 2'd3
   } op_t;

   // Full/empty qualification is applied by the caller per operation.
   function automatic op_t decode_op(input logic push, input logic pop);
      case ({push, pop})
         2'b10:   return OP_PUSH;
         2'b01:   return OP_POP;
         2'b11:   return OP_SWAP;
         default: return OP_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/lifo_ptr.sv
// rtl/lifo_ptr.sv - up/down stack pointer and count register with terminal carry
module lifo_ptr #(
   parameter int PTR_W = 5
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             en,
   input  logic             up,
   output logic [PTR_W:0]   count,
   output logic [PTR_W-1:0] sp,
   output logic [PTR_W-1:0] top,
   output logic             carry
);

   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [PTR_W:0] cnt_q;

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         cnt_q <= '0;
      end else if (en) begin
         if (up) cnt_q <= cnt_q + CNT_ONE;
         else    cnt_q <= cnt_q - CNT_ONE;
      end
   end

   // At count == DEPTH the low bits read zero, so top lands on DEPTH-1 and the MSB is the carry.
   assign count = cnt_q;
   assign sp    = cnt_q[PTR_W-1:0];
   assign top   = cnt_q[PTR_W-1:0] - PTR_ONE;
   assign carry = cnt_q[PTR_W];

endmodule

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - LIFO stack with registered pop data and sticky error flags; option LIFO_ALMOST_FLAGS_EN
module lifo_stack
   import lifo_pkg::*;
#(
   parameter int DATA_W = LIFO_DATA_W,
   parameter int DEPTH  = LIFO_DEPTH,
   parameter int PTR_W  = LIFO_PTR_W
`ifdef LIFO_ALMOST_FLAGS_EN
   ,
   parameter int AF_MARGIN = 2,
   parameter int AE_MARGIN = 2
`endif
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              full,
   output logic              empty,
   output logic [PTR_W:0]    count,
   output logic              overflow,
   output logic              underflow
`ifdef LIFO_ALMOST_FLAGS_EN
   ,
   output logic              almost_full,
   output logic              almost_empty
`endif
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  sp;
   logic [PTR_W-1:0]  top;
   logic              carry;
   logic              ptr_en;
   logic              ptr_up;
   logic              mem_we;
   logic [PTR_W-1:0]  mem_waddr;
   op_t               op;

   lifo_ptr #(.PTR_W(PTR_W)) u_ptr (
      .CLK   (CLK),
      .Reset (Reset),
      .en    (ptr_en),
      .up    (ptr_up),
      .count (count),
      .sp    (sp),
      .top   (top),
      .carry (carry)
   );

   assign full  = carry;
   assign empty = (count == '0);
   assign op    = decode_op(push, pop);

   always_comb begin
      ptr_en    = 1'b0;
      ptr_up    = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = sp;
      case (op)
         OP_PUSH: begin
            if (!full) begin
               ptr_en = 1'b1;
               ptr_up = 1'b1;
               mem_we = 1'b1;
            end
         end
         OP_POP: begin
            if (!empty) ptr_en = 1'b1;
         end
         // Swap overwrites the old top in place; an empty swap is a pure bypass.
         OP_SWAP: begin
            if (!empty) begin
               mem_we    = 1'b1;
               mem_waddr = top;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset && mem_we) mem[mem_waddr] <= din;
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         case (op)
            OP_PUSH: begin
               if (full) overflow <= 1'b1;
            end
            OP_POP: begin
               if (empty) begin
                  underflow <= 1'b1;
               end else begin
                  dout       <= mem[top];
                  dout_valid <= 1'b1;
               end
            end
            OP_SWAP: begin
               dout       <= empty ? din : mem[top];
               dout_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef LIFO_ALMOST_FLAGS_EN
   localparam logic [PTR_W:0] AF_LEVEL = (PTR_W+1)'(DEPTH - AF_MARGIN);
   localparam logic [PTR_W:0] AE_LEVEL = (PTR_W+1)'(AE_MARGIN);

   assign almost_full  = (count >= AF_LEVEL);
   assign almost_empty = (count <= AE_LEVEL);
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - directed self-checking bench for lifo_stack
module tb_lifo_stack;

   logic       CLK = 1'b0;
   logic       Reset;
   logic       push;
   logic       pop;
   logic [7:0] din;
   logic [7:0] dout;
   logic       dout_valid;
   logic       full;
   logic       empty;
   logic [5:0] count;
   logic       overflow;
   logic       underflow;
`ifdef LIFO_ALMOST_FLAGS_EN
   logic       almost_full;
   logic       almost_empty;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   lifo_stack dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .push       (push),
      .pop        (pop),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .overflow   (overflow),
      .underflow  (underflow)
`ifdef LIFO_ALMOST_FLAGS_EN
      ,
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic rst_n, input logic p, input logic q, input logic [7:0] d);
      Reset = rst_n;
      push  = p;
      pop   = q;
      din   = d;
      @(posedge CLK);
      #1;
      Reset = 1'b1;
      push  = 1'b0;
      pop   = 1'b0;
   endtask

   initial begin
      Reset = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      din   = 8'h00;
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_dout", dout, 0);
      check("rst_valid", dout_valid, 0);
      check("rst_ovf", overflow, 0);
      check("rst_unf", underflow, 0);

      // basic push/pop ordering
      step(1'b1, 1'b1, 1'b0, 8'h11);
      check("p1_valid", dout_valid, 0);
      step(1'b1, 1'b1, 1'b0, 8'h22);
      step(1'b1, 1'b1, 1'b0, 8'h33);
      check("p3_count", count, 3);
      check("p3_empty", empty, 0);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check("pop1_dout", dout, 8'h33);
      check("pop1_valid", dout_valid, 1);
      check("pop1_count", count, 2);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check("pop2_dout", dout, 8'h22);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check("pop3_dout", dout, 8'h11);
      check("pop3_count", count, 0);
      check("pop3_empty", empty, 1);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      check("idle_valid", dout_valid, 0);
      check("idle_dout", dout, 8'h11);

      // fill, overflow, pop top
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 1'b1, 1'b0, 8'(i));
`ifdef LIFO_ALMOST_FLAGS_EN
         if (i == 28) check("af_29", almost_full, 0);
         if (i == 29) check("af_30", almost_full, 1);
`endif
         if (i == 30) check("full_31", full, 0);
      end
      check("fill_full", full, 1);
      check("fill_count", count, 32);
      check("fill_ovf", overflow, 0);
      step(1'b1, 1'b1, 1'b0, 8'hAA);
      check("ovf_set", overflow, 1);
      check("ovf_count", count, 32);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check("ovf_pop_dout", dout, 8'h1F);
      check("ovf_pop_count", count, 31);
      check("ovf_pop_full", full, 0);
      check("ovf_sticky", overflow, 1);
      step(1'b1, 1'b1, 1'b0, 8'hBB);
      step(1'b1, 1'b1, 1'b1, 8'hCC);
      check("swap_full_dout", dout, 8'hBB);
      check("swap_full_count", count, 32);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check("swap_full_pop", dout, 8'hCC);
`ifdef LIFO_ALMOST_FLAGS_EN
      for (int n = 31; n > 2; n--) begin
         step(1'b1, 1'b0, 1'b1, 8'h00);
         if (n == 4) check("ae_3", almost_empty, 0);
         if (n == 3) check("ae_2", almost_empty, 1);
      end
      check("ae_count", count, 2);
`endif

      // underflow from reset
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("rst2_ovf", overflow, 0);
      check("rst2_count", count, 0);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check("unf_set", underflow, 1);
      check("unf_valid", dout_valid, 0);
      check("unf_count", count, 0);
      check("unf_dout", dout, 0);
      step(1'b1, 1'b1, 1'b0, 8'h5A);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check("unf_pop_dout", dout, 8'h5A);
      check("unf_pop_valid", dout_valid, 1);
      check("unf_sticky", underflow, 1);

      // simultaneous push/pop
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b0, 8'h43);
      step(1'b1, 1'b1, 1'b0, 8'h44);
      step(1'b1, 1'b1, 1'b1, 8'h99);
      check("swap_dout", dout, 8'h44);
      check("swap_valid", dout_valid, 1);
      check("swap_count", count, 2);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check("swap_pop_dout", dout, 8'h99);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check("swap_pop2_dout", dout, 8'h43);
      step(1'b1, 1'b1, 1'b1, 8'h77);
      check("byp_dout", dout, 8'h77);
      check("byp_valid", dout_valid, 1);
      check("byp_count", count, 0);
      check("byp_unf", underflow, 0);
      check("byp_ovf", overflow, 0);

      // reset mid-operation
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check("pre_unf", underflow, 1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h60 + i));
      check("pre_count", count, 5);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("mid_valid", dout_valid, 0);
      check("mid_count", count, 0);
      check("mid_empty", empty, 1);
      check("mid_unf", underflow, 0);
      check("mid_dout", dout, 0);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check("post_unf", underflow, 1);
      check("post_valid", dout_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
